// File: rtl/sdm_cic_decimator.sv
// 3rd-order CIC decimator turning a 1-bit sigma-delta stream into saturated signed PCM words.
// Optional build macro CIC_SETTLE_MASK_EN hides the first three comb outputs after reset.
module sdm_cic_decimator #(
   parameter int LOG2_DECIM = 6,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        BIT_IN,
   output logic signed [OUT_WIDTH-1:0] PCM_OUT,
   output logic                        PCM_VALID,
   input  logic                        PCM_READY,
   output logic                        OVERRUN
);

   localparam int ACC_WIDTH = 3*LOG2_DECIM + 2;
   localparam int SHIFT     = 3*LOG2_DECIM + 1 - OUT_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] C_MAX = ACC_WIDTH'((2**(3*LOG2_DECIM)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] C_MIN = -ACC_WIDTH'(2**(3*LOG2_DECIM));
   localparam logic signed [OUT_WIDTH-1:0] P_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] P_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   logic        [LOG2_DECIM-1:0] count;
   logic signed [ACC_WIDTH-1:0]  i1, i2, i3;
   logic signed [ACC_WIDTH-1:0]  s, d1, d2, d3, c3_q;
   logic signed [ACC_WIDTH-1:0]  step, c1, c2, c3;
   logic signed [OUT_WIDTH-1:0]  pcm_next;
   logic                         tick_q, comb_q, load;

   always_comb begin
      step = BIT_IN ? ACC_WIDTH'(1) : '1;
      c1   = s - d1;
      c2   = c1 - d2;
      c3   = c2 - d3;
   end

   // Saturate, then keep the bits that an arithmetic right shift by SHIFT would leave.
   always_comb begin
      if (c3_q > C_MAX)
         pcm_next = P_MAX;
      else if (c3_q < C_MIN)
         pcm_next = P_MIN;
      else
         pcm_next = c3_q[SHIFT +: OUT_WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         i1     <= '0;
         i2     <= '0;
         i3     <= '0;
         s      <= '0;
         tick_q <= 1'b0;
      end else begin
         i1     <= i1 + step;
         i2     <= i2 + i1;
         i3     <= i3 + i2;
         count  <= count + LOG2_DECIM'(1);
         tick_q <= (count == '1);
         if (count == '1)
            s <= i3 + i2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1     <= '0;
         d2     <= '0;
         d3     <= '0;
         c3_q   <= '0;
         comb_q <= 1'b0;
      end else begin
         comb_q <= tick_q;
         if (tick_q) begin
            d1   <= s;
            d2   <= c1;
            d3   <= c2;
            c3_q <= c3;
         end
      end
   end

`ifdef CIC_SETTLE_MASK_EN
   logic [1:0] settle_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         settle_cnt <= '0;
      else if (comb_q && settle_cnt != 2'd3)
         settle_cnt <= settle_cnt + 2'd1;
   end

   assign load = comb_q && (settle_cnt == 2'd3);
`else
   assign load = comb_q;
`endif

   // A load coinciding with an accept hands the old word over, so it is not an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PCM_OUT   <= '0;
         PCM_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
      end else if (load) begin
         PCM_OUT   <= pcm_next;
         PCM_VALID <= 1'b1;
         if (PCM_VALID && !PCM_READY)
            OVERRUN <= 1'b1;
      end else if (PCM_VALID && PCM_READY) begin
         PCM_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Directed bench for sdm_cic_decimator at default parameters (R=64, 16-bit output).
module tb_sdm_cic_decimator;

   logic               clk = 1'b0;
   logic               rst;
   logic               BIT_IN;
   logic               PCM_READY;
   logic signed [15:0] PCM_OUT;
   logic               PCM_VALID;
   logic               OVERRUN;

   int n_pass = 0;
   int n_fail = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int ph     = 0;
   int mode   = 0;
   int at     = 0;

   sdm_cic_decimator #(.LOG2_DECIM(6), .OUT_WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .BIT_IN    (BIT_IN),
      .PCM_OUT   (PCM_OUT),
      .PCM_VALID (PCM_VALID),
      .PCM_READY (PCM_READY),
      .OVERRUN   (OVERRUN)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: all ones, 1: all zeros, 2: 1010..., 3: 1110...
   task automatic drive();
      case (mode)
         0:       BIT_IN = 1'b1;
         1:       BIT_IN = 1'b0;
         2:       BIT_IN = (ph % 2 == 0);
         default: BIT_IN = (ph % 4 != 3);
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      ph++;
      drive();
   endtask

   task automatic wait_valid(output int when);
      when = -1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (PCM_VALID) begin
            when = cyc;
            return;
         end
      end
      check("valid_timeout", int'(PCM_VALID), 1);
   endtask

   initial begin
      rst       = 1'b1;
      PCM_READY = 1'b1;
      mode      = 0;
      drive();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset in the middle of a window
      repeat (30) tick();
      rst = 1'b1;
      #2;
      check("rst_pcm", int'(PCM_OUT), 0);
      check("rst_valid", int'(PCM_VALID), 0);
      check("rst_ovr", int'(OVERRUN), 0);
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;

`ifndef CIC_SETTLE_MASK_EN
      wait_valid(at);
      check("w1_lat", at, 66);
      check("w1_val", int'(PCM_OUT), 5208);
      tick();
      check("w1_drop", int'(PCM_VALID), 0);
      wait_valid(at);
      check("w2_lat", at, 130);
      check("w2_val", int'(PCM_OUT), 27048);
      wait_valid(at);
      check("w3_lat", at, 194);
      check("w3_val", int'(PCM_OUT), 32767);
`endif
      wait_valid(at);
      check("w4_lat", at, 258);
      check("w4_val", int'(PCM_OUT), 32767);
      check("w4_ovr", int'(OVERRUN), 0);
      wait_valid(at);
      check("w5_lat", at, 322);
      check("w5_val", int'(PCM_OUT), 32767);

      // Constant zeros
      mode = 1;
      drive();
      repeat (3) wait_valid(at);
      wait_valid(at);
      check("zero4_lat", at, 578);
      check("zero4_val", int'(PCM_OUT), -32768);
      wait_valid(at);
      check("zero5_lat", at, 642);
      check("zero5_val", int'(PCM_OUT), -32768);

      // Alternating 1,0
      mode = 2;
      drive();
      repeat (3) wait_valid(at);
      wait_valid(at);
      check("alt4_val", int'(PCM_OUT), 0);
      wait_valid(at);
      check("alt5_val", int'(PCM_OUT), 0);

      // 75% ones
      mode = 3;
      drive();
      repeat (3) wait_valid(at);
      wait_valid(at);
      check("p75_4_val", int'(PCM_OUT), 16384);
      wait_valid(at);
      check("p75_5_val", int'(PCM_OUT), 16384);

      // Load coincident with accept
      PCM_READY = 1'b0;
      repeat (63) tick();
      check("hold_valid", int'(PCM_VALID), 1);
      PCM_READY = 1'b1;
      tick();
      check("coinc_valid", int'(PCM_VALID), 1);
      check("coinc_ovr", int'(OVERRUN), 0);
      check("coinc_val", int'(PCM_OUT), 16384);
      tick();
      check("coinc_drop", int'(PCM_VALID), 0);

      // Overrun
      PCM_READY = 1'b0;
      wait_valid(at);
      check("ovr_first_val", int'(PCM_OUT), 16384);
      check("ovr_first_flag", int'(OVERRUN), 0);
      repeat (64) tick();
      check("ovr_second_flag", int'(OVERRUN), 1);
      check("ovr_second_valid", int'(PCM_VALID), 1);
      mode = 1;
      drive();
      repeat (320) tick();
      check("ovr_latest_val", int'(PCM_OUT), -32768);
      check("ovr_sticky1", int'(OVERRUN), 1);
      PCM_READY = 1'b1;
      tick();
      check("ovr_accept_drop", int'(PCM_VALID), 0);
      check("ovr_sticky2", int'(OVERRUN), 1);
      check("ovr_stable_val", int'(PCM_OUT), -32768);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
